keypad_scan: RTL and testbench
==============================

# keypad_scan

Scans a 4x4 hex keypad (active-low columns driven, active-low rows sensed), debounces it and emits one event per accepted key press. Decimal digit keys are accumulated into a 4-digit entry value. The entry value is zero-extended to 32 bits and drives the display value input of the seven-segment driver, so the board shows what is being typed. This is the input side of the board's front panel; the seven-segment driver is the output side.

## Interface
- SCAN_TICKS, 100000: clock cycles each column stays driven.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release.
- REPEAT_SCANS, 50: scans between repeated events while a key is held. Used only with autorepeat enabled.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active low, asynchronous to clk.
- col  out  4  column drive, one-cold.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_code  out  4  code of the last accepted key; held between events.
- value  out  32  live entry value, 0..9999, upper 18 bits always 0.
- entry_valid  out  1  one-cycle pulse when ENTER is accepted.
- entry_value  out  32  value latched at the last ENTER.

## Operation
- row passes through a 2-flop synchronizer before any use.
- Column counter cycles 0..3. col = ~(1 << idx). Reset drives col = 4'b1110.
- The synchronized rows are sampled on the last tick of each column slot. After column 3 the scan result is one of three cases:
  - NONE: no row low.
  - ONE(code): exactly one key low.
  - MULTI: two or more keys low.
- Keymap, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM states:
  - IDLE: counts consecutive ONE(code) scans with the same code. A different code restarts the count at 1. NONE or MULTI resets the count. When the count reaches DEBOUNCE_SCANS, emit the event and go to HELD.
  - HELD: counts consecutive NONE scans. ONE or MULTI resets the count. When the count reaches DEBOUNCE_SCANS, go to IDLE. A different key pressed while in HELD produces no event.
- Event actions, applied to value in the same cycle key_valid is high:
  - 0-9: value = (value*10 + d) mod 10000.
  - B (backspace): value = value/10.
  - C (clear): value = 0.
  - E (enter): entry_value = value; entry_valid pulses; value unchanged.
  - A, D, F: key_valid and key_code only; value unchanged.
- Arithmetic: compute value*10 + d in 18 bits, then reduce mod 10000; the result never exceeds 9999.

## Timing
- Scan period is 4*SCAN_TICKS cycles.
- key_valid rises 1 cycle after the sample edge that completes the DEBOUNCE_SCANS-th matching scan.
- key_code, value, entry_value and entry_valid update on the same edge key_valid rises. They are registered outputs with no extra latency.
- At most one event per scan; key_valid never high on consecutive cycles.
- Reset values: col=4'b1110, key_valid=0, key_code=0, value=0, entry_valid=0, entry_value=0, FSM=IDLE, all counters 0.
- Reset mid-press: asynchronous clear. After reset release the held key must be re-debounced from IDLE and produces exactly one event.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined: while in HELD with the same ONE(code) each scan, repeat the event every REPEAT_SCANS scans. Repeats apply the same value action. The repeat counter restarts on any non-matching scan.
- KEYPAD_AUTOREPEAT_EN undefined: exactly one event per press, and REPEAT_SCANS is unused.

## Structure
- Package keypad_pkg contains:
  - the FSM state typedef (IDLE, HELD);
  - the scan-result typedef (NONE/ONE/MULTI);
  - key constants KEY_BACK=4'hB, KEY_CLEAR=4'hC, KEY_ENTER=4'hE;
  - the keymap function (row, col) -> code.
- Sub-module keypad_entry: the decimal accumulator. Inputs are key_valid and key_code; outputs are value, entry_valid and entry_value.
- keypad_scan holds the synchronizer, the column counter, the scan FSM and the debounce logic.

## Test plan
Bench uses SCAN_TICKS=4, DEBOUNCE_SCANS=2.
1. Hold row0 low during col1 slots for 3 scans, then release for 3 scans -> exactly one key_valid, key_code=2, value=2.
2. Press 1,2,3,4,5 in sequence with clean releases -> value sequence 1, 12, 123, 1234, then 2345.
3. Value 1234; press B, then E -> value=123; entry_valid pulses once with entry_value=123. Then press C -> value=0, entry_value stays 123.
4. Key 5 alternating pressed/released every scan (bounce) for 6 scans, then stable -> no event during the bounce; one event once stable for 2 scans.
5. Keys 1 and 6 held together -> MULTI, no event. Release 6 -> event for key 1 after 2 scans.
6. Assert rst_n low mid-HELD with key 7 held -> all outputs return to reset values immediately. After release, one event with key_code=7. With KEYPAD_AUTOREPEAT_EN and REPEAT_SCANS=3, holding 7 for 10 scans after acceptance -> 3 further events.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and the keymap for the front-panel keypad.
//   scan_state_e : scan FSM states (IDLE, HELD)
//   scan_res_e   : classification of one full keypad scan (NONE, ONE, MULTI)
//   KEY_*        : codes of the keys that edit the entry value
//   key_map()    : (row, col) -> key code
package keypad_pkg;

    typedef enum logic {IDLE, HELD} scan_state_e;

    typedef enum logic [1:0] {NONE, ONE, MULTI} scan_res_e;

    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry.sv
// keypad_entry: decimal accumulator behind the keypad.
//   clk, rst_n   : clock, async active-low reset
//   key_valid    : key event strobe (registered here on the same edge the
//                  scanner registers its own key_valid)
//   key_code     : code of that event
//   value        : live entry value 0..9999, zero-extended
//   entry_valid  : one-cycle pulse when ENTER is accepted
//   entry_value  : value captured at the last ENTER
module keypad_entry
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [31:0] value,
    output logic        entry_valid,
    output logic [31:0] entry_value
);

    logic [13:0] value_q, value_d;
    logic [13:0] entry_q;
    logic        entry_valid_q;
    logic [17:0] shifted;

    always_comb begin
        shifted = 18'(value_q) * 18'd10 + 18'(key_code);
        value_d = value_q;
        if (key_valid) begin
            if (key_code <= 4'd9) begin
                value_d = 14'(shifted % 18'd10000);
            end else if (key_code == KEY_BACK) begin
                value_d = value_q / 14'd10;
            end else if (key_code == KEY_CLEAR) begin
                value_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q       <= '0;
            entry_q       <= '0;
            entry_valid_q <= 1'b0;
        end else begin
            value_q       <= value_d;
            entry_valid_q <= key_valid && (key_code == KEY_ENTER);
            if (key_valid && (key_code == KEY_ENTER)) begin
                entry_q <= value_q;
            end
        end
    end

    assign value       = {18'b0, value_q};
    assign entry_valid = entry_valid_q;
    assign entry_value = {18'b0, entry_q};

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad scanner, debouncer and entry front end.
//   clk, rst_n   : clock, async active-low reset
//   row          : keypad rows, active low, asynchronous
//   col          : column drive, one-cold
//   key_valid    : one-cycle pulse per accepted key event
//   key_code     : code of the last accepted key
//   value        : live entry value
//   entry_valid  : pulse on ENTER
//   entry_value  : value latched at the last ENTER
// Build option: define KEYPAD_AUTOREPEAT_EN to repeat a held key every
// REPEAT_SCANS scans.
//
// state | meaning
// IDLE  | no key held; debouncing a candidate ONE(code) press
// HELD  | key accepted; debouncing the release (NONE scans)
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] value,
    output logic        entry_valid,
    output logic [31:0] entry_value
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    // One width for the debounce and repeat counters, large enough for either.
    localparam int CW = $clog2(((DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS
                                                                 : REPEAT_SCANS) + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DB_N      = CW'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_N     = CW'(REPEAT_SCANS);
`endif

    logic [3:0]    row_meta_q, row_sync_q;
    logic [TW-1:0] tick_q;
    logic [1:0]    col_idx_q;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic          scan_done_q;
    scan_res_e     scan_res_q, res_d;
    logic [3:0]    scan_code_q;
    logic [2:0]    n_low, hits_sum;
    logic [1:0]    first_r;

    scan_state_e   state_q;
    logic [CW-1:0] db_cnt_q, match_cnt;
    logic [3:0]    cand_q;
    logic          key_valid_q, fire;
    logic [3:0]    key_code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CW-1:0] rep_cnt_q;
`endif

    assign col = ~(4'b0001 << col_idx_q);

    // Fold the current column into the running scan: hits saturates at 2
    // (MULTI), the code is only kept while exactly one key has been seen.
    always_comb begin
        n_low   = '0;
        first_r = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                n_low   = n_low + 3'd1;
                first_r = 2'(r);
            end
        end
        hits_sum   = {1'b0, hits_q} + n_low;
        hits_d     = (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
        acc_code_d = (hits_q == 2'd0 && n_low == 3'd1) ? key_map(first_r, col_idx_q)
                                                        : acc_code_q;
        res_d      = (hits_d == 2'd0) ? NONE : ((hits_d == 2'd1) ? ONE : MULTI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            tick_q      <= '0;
            col_idx_q   <= '0;
            hits_q      <= '0;
            acc_code_q  <= '0;
            scan_done_q <= 1'b0;
            scan_res_q  <= NONE;
            scan_code_q <= '0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            scan_done_q <= 1'b0;
            if (tick_q == '0) begin
                tick_q    <= TICK_LAST;
                col_idx_q <= col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) begin
                    scan_done_q <= 1'b1;
                    scan_res_q  <= res_d;
                    scan_code_q <= acc_code_d;
                    hits_q      <= '0;
                    acc_code_q  <= '0;
                end else begin
                    hits_q     <= hits_d;
                    acc_code_q <= acc_code_d;
                end
            end else begin
                tick_q <= tick_q - TW'(1);
            end
        end
    end

    // Event decode: shared by the FSM and the accumulator so both update on
    // the same edge.
    always_comb begin
        match_cnt = (db_cnt_q != '0 && cand_q == scan_code_q) ? db_cnt_q + CW'(1) : CW'(1);
        fire      = 1'b0;
        if (scan_done_q && scan_res_q == ONE) begin
            if (state_q == IDLE && match_cnt == DB_N) begin
                fire = 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (state_q == HELD && scan_code_q == key_code_q && rep_cnt_q + CW'(1) == REP_N) begin
                fire = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            key_valid_q <= fire;
            if (fire) begin
                key_code_q <= scan_code_q;
            end
            if (scan_done_q) begin
                case (state_q)
                    IDLE: begin
                        if (scan_res_q == ONE) begin
                            cand_q <= scan_code_q;
                            if (fire) begin
                                state_q  <= HELD;
                                db_cnt_q <= '0;
                            end else begin
                                db_cnt_q <= match_cnt;
                            end
                        end else begin
                            db_cnt_q <= '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_q <= '0;
`endif
                    end
                    default: begin
                        if (scan_res_q == NONE) begin
                            if (db_cnt_q + CW'(1) == DB_N) begin
                                state_q  <= IDLE;
                                db_cnt_q <= '0;
                            end else begin
                                db_cnt_q <= db_cnt_q + CW'(1);
                            end
                        end else begin
                            db_cnt_q <= '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (scan_res_q == ONE && scan_code_q == key_code_q) begin
                            rep_cnt_q <= fire ? '0 : rep_cnt_q + CW'(1);
                        end else begin
                            rep_cnt_q <= '0;
                        end
`endif
                    end
                endcase
            end
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

    keypad_entry u_entry (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (fire),
        .key_code    (scan_code_q),
        .value       (value),
        .entry_valid (entry_valid),
        .entry_value (entry_value)
    );

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    localparam int ST = 4;
    localparam int SCAN_CYC = 4 * ST;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;
    logic        entry_valid;
    logic [31:0] entry_value;

    logic [15:0] pressed = '0;   // bit r*4+c

    typedef struct {
        logic [3:0]  code;
        logic [31:0] val;
        logic        ev;
        logic [31:0] evv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   n_events = 0;
    int   n_expected = 0;
    logic prev_kv = 1'b0;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .value       (value),
        .entry_valid (entry_valid),
        .entry_value (entry_value)
    );

    // Keypad matrix: a pressed key shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pos_of(input logic [3:0] c);
        case (c)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
            4'h0: return 12; 4'hF: return 13; 4'hE: return 14; default: return 15;
        endcase
    endfunction

    task automatic expect_ev(input logic [3:0] c, input int v, input logic ev, input int evv);
        exp_t e;
        e.code = c; e.val = v; e.ev = ev; e.evv = evv;
        sb.push_back(e);
        n_expected++;
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN_CYC) @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] c);
        pressed[pos_of(c)] = 1'b1;
        wait_scans(3);
        pressed[pos_of(c)] = 1'b0;
        wait_scans(3);
    endtask

    task automatic tap_exp(input logic [3:0] c, input int v, input logic ev, input int evv);
        expect_ev(c, v, ev, evv);
        tap(c);
    endtask

    // Monitor: pops the scoreboard on every key event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_kv = 1'b0;
            end else begin
                if (key_valid) begin
                    n_events++;
                    check("key_valid_back_to_back", {31'b0, prev_kv}, 32'd0);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_event: key_code=%0h value=%0d, no event expected",
                                 key_code, value);
                    end else begin
                        e = sb.pop_front();
                        check("key_code", {28'b0, key_code}, {28'b0, e.code});
                        check("value", value, e.val);
                        check("entry_valid", {31'b0, entry_valid}, {31'b0, e.ev});
                        check("entry_value", entry_value, e.evv);
                    end
                end else if (entry_valid) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL entry_valid_without_key: entry_valid=1, expected 0");
                end
                prev_kv = key_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, {28'b0, col}, 32'he);
        check({tag, "_key_valid"}, {31'b0, key_valid}, 32'd0);
        check({tag, "_key_code"}, {28'b0, key_code}, 32'd0);
        check({tag, "_value"}, value, 32'd0);
        check({tag, "_entry_valid"}, {31'b0, entry_valid}, 32'd0);
        check({tag, "_entry_value"}, entry_value, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_scans(1);

        // 1: single key 2, one event
        tap_exp(4'h2, 2, 1'b0, 0);

        // 2: digit accumulation with mod-10000 wrap
        tap_exp(4'hC, 0, 1'b0, 0);
        tap_exp(4'h1, 1, 1'b0, 0);
        tap_exp(4'h2, 12, 1'b0, 0);
        tap_exp(4'h3, 123, 1'b0, 0);
        tap_exp(4'h4, 1234, 1'b0, 0);
        tap_exp(4'h5, 2345, 1'b0, 0);

        // 3: backspace, enter, clear
        tap_exp(4'hC, 0, 1'b0, 0);
        tap_exp(4'h1, 1, 1'b0, 0);
        tap_exp(4'h2, 12, 1'b0, 0);
        tap_exp(4'h3, 123, 1'b0, 0);
        tap_exp(4'h4, 1234, 1'b0, 0);
        tap_exp(4'hB, 123, 1'b0, 0);
        tap_exp(4'hE, 123, 1'b1, 123);
        tap_exp(4'hC, 0, 1'b0, 123);

        // 4: bouncing key 5, no event until stable
        for (int i = 0; i < 6; i++) begin
            pressed[pos_of(4'h5)] = (i % 2 == 0);
            wait_scans(1);
        end
        tap_exp(4'h5, 5, 1'b0, 123);

        // 5: two keys together -> MULTI, then release 6
        pressed[pos_of(4'h1)] = 1'b1;
        pressed[pos_of(4'h6)] = 1'b1;
        wait_scans(3);
        expect_ev(4'h1, 51, 1'b0, 123);
        pressed[pos_of(4'h6)] = 1'b0;
        wait_scans(3);
        pressed[pos_of(4'h1)] = 1'b0;
        wait_scans(3);

        // 6: reset while key 7 is held
        expect_ev(4'h7, 517, 1'b0, 123);
        pressed[pos_of(4'h7)] = 1'b1;
        wait_scans(3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_ev(4'h7, 7, 1'b0, 0);
`ifdef KEYPAD_AUTOREPEAT_EN
        expect_ev(4'h7, 77, 1'b0, 0);
        expect_ev(4'h7, 777, 1'b0, 0);
        expect_ev(4'h7, 7777, 1'b0, 0);
`endif
        wait_scans(13);
        pressed[pos_of(4'h7)] = 1'b0;
        wait_scans(4);

        check("scoreboard_drained", sb.size(), 32'd0);
        check("event_count", n_events, n_expected);
        check("final_key_code", {28'b0, key_code}, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
